// File: rtl/ram_bist_ctrl.sv
// March C- style BIST sequencer for a single-port-per-direction synchronous RAM.
// Walks elements M0..M5 and stops at the first read mismatch with its location captured.
module ram_bist_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [2:0]       fail_phase,
  output logic [AW-1:0]    fail_addr,
  output logic [WIDTH-1:0] fail_exp,
  output logic [WIDTH-1:0] fail_got,
  output logic             ram_wen,
  output logic             ram_ren,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data,
  input  logic [WIDTH-1:0] ram_q,
  output logic [2:0]       fsm_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_M0   = 3'd1;
  localparam logic [2:0] S_M1   = 3'd2;
  localparam logic [2:0] S_M2   = 3'd3;
  localparam logic [2:0] S_M3   = 3'd4;
  localparam logic [2:0] S_M4   = 3'd5;
  localparam logic [2:0] S_M5   = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [WIDTH-1:0] ALL0      = '0;
  localparam logic [WIDTH-1:0] ALL1      = '1;
  localparam logic [AW-1:0]    ADDR_LAST = AW'(DEPTH - 1);

  // Handshake: start is accepted on any edge where busy=0; busy stays high for the
  // whole march and done is a level that holds until the next accepted start or res.

  logic [2:0]       state;
  logic [AW-1:0]    addr;
  logic             cmp_cycle;
  logic             in_rw;
  logic             descending;
  logic             last_addr;
  logic             match;
  logic [WIDTH-1:0] exp_word;
  logic [WIDTH-1:0] wr_word;
  logic [AW-1:0]    next_addr;

  always_comb begin
    in_rw      = (state >= S_M1) && (state <= S_M5);
    descending = (state >= S_M3) && (state <= S_M5);
    exp_word   = ((state == S_M2) || (state == S_M4)) ? ALL1 : ALL0;
    wr_word    = ((state == S_M1) || (state == S_M3)) ? ALL1 : ALL0;
    match      = (ram_q == exp_word);
    last_addr  = descending ? (addr == '0) : (addr == ADDR_LAST);
    next_addr  = descending ? (addr - AW'(1)) : (addr + AW'(1));
  end

  // The write-back in a compare cycle is gated by the live read data, so a
  // mismatching word is never overwritten before it is reported.
  always_comb begin
    ram_ren  = in_rw && !cmp_cycle;
    ram_wen  = (state == S_M0) || (in_rw && (state != S_M5) && cmp_cycle && match);
    ram_data = ((state >= S_M0) && (state <= S_M4)) ? wr_word : ALL0;
    ram_addr = addr;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= S_IDLE;
      addr       <= '0;
      cmp_cycle  <= 1'b0;
      fail       <= 1'b0;
      fail_phase <= 3'd0;
      fail_addr  <= '0;
      fail_exp   <= '0;
      fail_got   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_M0;
            addr       <= '0;
            cmp_cycle  <= 1'b0;
            fail       <= 1'b0;
            fail_phase <= 3'd0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
          end
        end
        S_M0: begin
          if (last_addr) begin
            state <= S_M1;
            addr  <= '0;
          end else begin
            addr <= next_addr;
          end
        end
        default: begin
          if (!cmp_cycle) begin
            cmp_cycle <= 1'b1;
          end else begin
            cmp_cycle <= 1'b0;
            if (!match) begin
              state      <= S_DONE;
              fail       <= 1'b1;
              fail_phase <= state - S_M0;
              fail_addr  <= addr;
              fail_exp   <= exp_word;
              fail_got   <= ram_q;
            end else if (last_addr) begin
              // M1 -> M2 stays ascending; every later element starts from the top.
              state <= state + 3'd1;
              addr  <= (state == S_M1) ? '0 : ADDR_LAST;
            end else begin
              addr <= next_addr;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    busy      = (state >= S_M0) && (state <= S_M5);
    done      = (state == S_DONE);
    fsm_state = state;
  end

endmodule
